// File: rtl/irrigation_scheduler.sv
// Tank inlet control with level hysteresis, debounced level alarm and
// round-robin zone irrigation over one shared pump. Every output is flop-driven.
module irrigation_scheduler #(
  parameter int unsigned ZONES   = 4,
  parameter int unsigned TW      = 16,
  parameter int unsigned MAX_RUN = 600,
  parameter int unsigned GAP     = 10,
  parameter int unsigned DEB     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             H,
  input  logic             M,
  input  logic             L,
  input  logic             Ua,
  input  logic             T,
  input  logic [ZONES-1:0] Us,
  input  logic             clr,
  output logic             Ve,
  output logic             Bs,
  output logic             Vs,
  output logic             Al,
  output logic [ZONES-1:0] zone_en,
  output logic             busy,
  output logic [ZONES-1:0] timeout_flags
);

  localparam int unsigned PW = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int unsigned SW = PW + 1;

  typedef enum logic {HOLD, FILL} fill_e;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} irr_e;

  fill_e            fill_q, fill_d;
  irr_e             st_q, st_d;
  logic             al_q, al_d;
  logic [TW-1:0]    deb_q, deb_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    cur_q, cur_d;
  logic             drip_q, drip_d;
  logic [ZONES-1:0] zen_q, zen_d;
  logic [ZONES-1:0] flags_q, flags_d;
  logic             bs_q, bs_d;
  logic             vs_q, vs_d;
  logic             busy_q, busy_d;

  logic             fault;
  logic             found;
  logic             end_run;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    cur_next;
  logic [SW-1:0]    idx;

  // Inconsistent sensor combination; an empty tank is not a fault.
  assign fault = (H & ~M) | (M & ~L) | (H & ~L);

  always_comb begin
    al_d  = al_q;
    deb_d = deb_q;
    if (tick) begin
      if (fault == al_q) begin
        deb_d = '0;
      end else if (deb_q >= TW'(DEB - 1)) begin
        al_d  = fault;
        deb_d = '0;
      end else begin
        deb_d = deb_q + TW'(1);
      end
    end
  end

  always_comb begin
    fill_d = fill_q;
    unique case (fill_q)
      HOLD:    if (!M && !al_q) fill_d = FILL;
      FILL:    if (H || al_q)   fill_d = HOLD;
      default: fill_d = HOLD;
    endcase
  end

  // First dry zone at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < ZONES; k++) begin
      idx = SW'(ptr_q) + SW'(k);
      if (idx >= SW'(ZONES)) idx = idx - SW'(ZONES);
      if (!found && !Us[idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    st_d     = st_q;
    tmr_d    = tmr_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    drip_d   = drip_q;
    flags_d  = clr ? '0 : flags_q;
    end_run  = 1'b0;
    cur_next = (cur_q == PW'(ZONES - 1)) ? '0 : cur_q + PW'(1);
    unique case (st_q)
      IDLE: begin
        if (found && L && !al_q) begin
          st_d   = RUN;
          cur_d  = sel;
          tmr_d  = '0;
          drip_d = Ua | T;
        end
      end
      RUN: begin
        // Abort outranks timeout, which outranks the zone going wet.
        if (!L || al_q) begin
          end_run = 1'b1;
        end else if (tick && (tmr_q >= TW'(MAX_RUN - 1))) begin
          end_run        = 1'b1;
          flags_d[cur_q] = 1'b1;
        end else if (Us[cur_q]) begin
          end_run = 1'b1;
        end else if (tick && (tmr_q != '1)) begin
          tmr_d = tmr_q + TW'(1);
        end
        if (end_run) begin
          st_d  = PAUSE;
          tmr_d = '0;
          ptr_d = cur_next;
        end
      end
      PAUSE: begin
        if (tick) begin
          if (tmr_q >= TW'(GAP - 1)) begin
            st_d  = IDLE;
            tmr_d = '0;
          end else if (tmr_q != '1) begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end
      default: st_d = IDLE;
    endcase
    busy_d = (st_d != IDLE);
    zen_d  = (st_d == RUN) ? (ZONES'(1) << cur_d) : '0;
    bs_d   = (st_d == RUN) && !drip_d;
    vs_d   = (st_d == RUN) && drip_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= HOLD;
      st_q    <= IDLE;
      al_q    <= 1'b0;
      deb_q   <= '0;
      tmr_q   <= '0;
      ptr_q   <= '0;
      cur_q   <= '0;
      drip_q  <= 1'b0;
      zen_q   <= '0;
      flags_q <= '0;
      bs_q    <= 1'b0;
      vs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      st_q    <= st_d;
      al_q    <= al_d;
      deb_q   <= deb_d;
      tmr_q   <= tmr_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      drip_q  <= drip_d;
      zen_q   <= zen_d;
      flags_q <= flags_d;
      bs_q    <= bs_d;
      vs_q    <= vs_d;
      busy_q  <= busy_d;
    end
  end

  assign Ve            = (fill_q == FILL);
  assign Al            = al_q;
  assign Bs            = bs_q;
  assign Vs            = vs_q;
  assign zone_en       = zen_q;
  assign busy          = busy_q;
  assign timeout_flags = flags_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: directed scenarios with literal expectations,
// then random stimulus, all outputs compared every cycle against a behavioural model.
module tb_irrigation_scheduler;

  localparam int NZ   = 4;
  localparam int MAXR = 600;
  localparam int G    = 10;
  localparam int D    = 3;

  logic          clk = 1'b0;
  logic          rst_n, tick, H, M, L, Ua, T, clr;
  logic [NZ-1:0] Us;
  logic          Ve, Bs, Vs, Al, busy;
  logic [NZ-1:0] zone_en, timeout_flags;

  int n_chk  = 0;
  int n_pass = 0;

  irrigation_scheduler #(
    .ZONES(NZ), .TW(16), .MAX_RUN(MAXR), .GAP(G), .DEB(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .H(H), .M(M), .L(L),
    .Ua(Ua), .T(T), .Us(Us), .clr(clr),
    .Ve(Ve), .Bs(Bs), .Vs(Vs), .Al(Al), .zone_en(zone_en),
    .busy(busy), .timeout_flags(timeout_flags)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit            e_ve = 1'b0, e_al = 1'b0, e_bs = 1'b0, e_vs = 1'b0, e_busy = 1'b0;
  logic [NZ-1:0] e_zen = '0, e_flags = '0;
  int            streak = 0, ticks = 0, zone = 0, nxt = 0;
  bit            running = 1'b0, pausing = 1'b0, drip = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
  endtask

  function automatic bit bit_of(input logic [NZ-1:0] v, input int i);
    logic [NZ-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  task automatic model_reset();
    e_ve = 0; e_al = 0; e_bs = 0; e_vs = 0; e_busy = 0;
    e_zen = '0; e_flags = '0;
    streak = 0; ticks = 0; zone = 0; nxt = 0;
    running = 0; pausing = 0; drip = 0;
  endtask

  task automatic model_step();
    bit fault, al0, hit, stop;
    int z;
    fault = (H & ~M) | (M & ~L) | (H & ~L);
    al0   = e_al;
    stop  = 0;
    if (tick) begin
      if (fault == al0) streak = 0;
      else begin
        streak++;
        if (streak >= D) begin e_al = fault; streak = 0; end
      end
    end
    if (e_ve) begin
      if (H || al0) e_ve = 0;
    end else if (!M && !al0) e_ve = 1;
    if (clr) e_flags = '0;
    if (running) begin
      if (tick) ticks++;
      if (!L || al0) stop = 1;
      else if (tick && ticks >= MAXR) begin
        e_flags = e_flags | (NZ'(1) << zone);
        stop = 1;
      end else if (bit_of(Us, zone)) stop = 1;
      if (stop) begin
        running = 0; pausing = 1; ticks = 0; nxt = (zone + 1) % NZ;
      end
    end else if (pausing) begin
      if (tick) ticks++;
      if (ticks >= G) begin pausing = 0; ticks = 0; end
    end else if (L && !al0) begin
      hit = 0;
      for (int k = 0; k < NZ; k++) begin
        z = (nxt + k) % NZ;
        if (!hit && !bit_of(Us, z)) begin hit = 1; zone = z; end
      end
      if (hit) begin running = 1; ticks = 0; drip = Ua | T; end
    end
    e_zen  = running ? (NZ'(1) << zone) : '0;
    e_bs   = running && !drip;
    e_vs   = running && drip;
    e_busy = running || pausing;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("Ve", 32'(Ve), 32'(e_ve));
    chk("Al", 32'(Al), 32'(e_al));
    chk("Bs", 32'(Bs), 32'(e_bs));
    chk("Vs", 32'(Vs), 32'(e_vs));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("zone_en", 32'(zone_en), 32'(e_zen));
    chk("timeout_flags", 32'(timeout_flags), 32'(e_flags));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 0; tick = 1; H = 0; M = 0; L = 0; Ua = 0; T = 0; clr = 0; Us = '1;
    cyc(3);
    chk("rst_Ve", 32'(Ve), 32'd0);
    chk("rst_zone_en", 32'(zone_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_Al", 32'(Al), 32'd0);
    chk("rst_flags", 32'(timeout_flags), 32'd0);
    rst_n = 1;
    cyc(1); chk("fill_start_Ve", 32'(Ve), 32'd1);
    L = 1; M = 1;
    cyc(2); chk("fill_midM_Ve", 32'(Ve), 32'd1);
    H = 1;
    cyc(1); chk("fill_full_Ve", 32'(Ve), 32'd0);
    chk("fill_full_Al", 32'(Al), 32'd0);

    // Level fault debounce
    M = 0;
    cyc(2); chk("deb_short_Al", 32'(Al), 32'd0);
    M = 1;
    cyc(2); chk("deb_restart_Al", 32'(Al), 32'd0);
    M = 0;
    cyc(2); chk("deb_2tick_Al", 32'(Al), 32'd0);
    cyc(1); chk("deb_set_Al", 32'(Al), 32'd1);
    cyc(2); chk("deb_forced_Ve", 32'(Ve), 32'd0);
    M = 1;
    cyc(2); chk("deb_hold_Al", 32'(Al), 32'd1);
    cyc(1); chk("deb_clear_Al", 32'(Al), 32'd0);

    // Round-robin over zones 0 and 2
    Us = 4'b1010;
    cyc(1); chk("rr_z0_en", 32'(zone_en), 32'h1);
    chk("rr_z0_Bs", 32'(Bs), 32'd1);
    chk("rr_z0_Vs", 32'(Vs), 32'd0);
    chk("rr_z0_busy", 32'(busy), 32'd1);
    Us = 4'b1011;
    cyc(1); chk("rr_pause_en", 32'(zone_en), 32'h0);
    chk("rr_pause_Bs", 32'(Bs), 32'd0);
    chk("rr_pause_busy", 32'(busy), 32'd1);
    cyc(10); chk("rr_gap_busy", 32'(busy), 32'd0);
    cyc(1); chk("rr_z2_en", 32'(zone_en), 32'h4);
    Us = 4'b1111;
    cyc(1); chk("rr_z2_end", 32'(zone_en), 32'h0);
    cyc(10); chk("rr_idle_busy", 32'(busy), 32'd0);

    // Drip mode held through the run, then timeout
    Us = 4'b1101; T = 1;
    cyc(1); chk("drip_en", 32'(zone_en), 32'h2);
    chk("drip_Vs", 32'(Vs), 32'd1);
    chk("drip_Bs", 32'(Bs), 32'd0);
    T = 0;
    cyc(5); chk("drip_held_Vs", 32'(Vs), 32'd1);
    chk("drip_held_Bs", 32'(Bs), 32'd0);
    cyc(594); chk("to_before_en", 32'(zone_en), 32'h2);
    chk("to_before_flags", 32'(timeout_flags), 32'h0);
    cyc(1); chk("to_end_en", 32'(zone_en), 32'h0);
    chk("to_flags", 32'(timeout_flags), 32'h2);
    chk("to_busy", 32'(busy), 32'd1);
    Us = 4'b1111; clr = 1;
    cyc(1); clr = 0;
    chk("clr_flags", 32'(timeout_flags), 32'h0);
    cyc(10);

    // Abort on low tank
    Us = 4'b0111;
    cyc(1); chk("abort_run_en", 32'(zone_en), 32'h8);
    chk("abort_run_Bs", 32'(Bs), 32'd1);
    cyc(3);
    H = 0; M = 0; L = 0;
    cyc(1); chk("abort_en", 32'(zone_en), 32'h0);
    chk("abort_Bs", 32'(Bs), 32'd0);
    chk("abort_Vs", 32'(Vs), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_flags", 32'(timeout_flags), 32'h0);
    cyc(20); chk("lowL_busy", 32'(busy), 32'd0);
    chk("lowL_en", 32'(zone_en), 32'h0);
    H = 1; M = 1; L = 1;
    cyc(1); chk("resume_en", 32'(zone_en), 32'h8);

    // Asynchronous reset between clock edges
    #1 rst_n = 0;
    #1;
    chk("arst_en", 32'(zone_en), 32'h0);
    chk("arst_Bs", 32'(Bs), 32'd0);
    chk("arst_Vs", 32'(Vs), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    Us = 4'b0101;
    cyc(2);
    rst_n = 1;
    cyc(1); chk("arst_first_en", 32'(zone_en), 32'h2);
    chk("arst_first_busy", 32'(busy), 32'd1);

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0: {H, M, L} = 3'b000;
          1: {H, M, L} = 3'b001;
          2: {H, M, L} = 3'b011;
          3: {H, M, L} = 3'b111;
          default: {H, M, L} = 3'($urandom);
        endcase
      end
      if ($urandom_range(0, 149) == 0) Us = NZ'($urandom);
      if ($urandom_range(0, 7) == 0) Ua = ~Ua;
      if ($urandom_range(0, 7) == 0) T = ~T;
      clr = ($urandom_range(0, 49) == 0);
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Clocked, parametrised successor to the single-bed combinational irrigation logic.
- Manages the tank inlet valve with level hysteresis.
- Debounces and latches the level-sensor alarm.
- Serves ZONES irrigation zones round-robin over one shared pump. Each run uses spray or drip, chosen at the start of the run and held until it ends.
- Sits between the sensor conditioning logic and the valve/pump drivers in the irrigation top level.

Parameters:
- ZONES, 4: number of irrigation zones (1..16).
- TW, 16: width of the run/pause/debounce timers.
- MAX_RUN, 600: maximum ticks a zone may irrigate in one run.
- GAP, 10: ticks with everything off between two zone runs.
- DEB, 3: ticks a level-fault condition must hold (or be absent) before the alarm sets (or clears).

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- tick, in, 1: timebase enable; all timers advance only on cycles with tick=1.
- H, in, 1: tank level high sensor.
- M, in, 1: tank level medium sensor.
- L, in, 1: tank level low sensor.
- Ua, in, 1: air-dry flag.
- T, in, 1: high-temperature flag.
- Us, in, ZONES: soil-wet flag per zone; 0 means the zone needs water.
- clr, in, 1: clears the timeout_flags register.
- Ve, out, 1: tank inlet valve.
- Bs, out, 1: spray pump.
- Vs, out, 1: drip valve.
- Al, out, 1: level alarm.
- zone_en, out, ZONES: one-hot zone valve select.
- busy, out, 1: an irrigation run or pause is in progress.
- timeout_flags, out, ZONES: sticky bit per zone, set when that zone's run hit MAX_RUN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0.
  - FSM in IDLE, round-robin pointer at 0, all timers 0.
  - Fill FSM in HOLD.
- All outputs come directly from flops; no combinational path from inputs to outputs.
- Level fault: fault = (H & ~M) | (M & ~L) | (H & ~L), i.e. an inconsistent sensor set.
  - Al sets after fault has been 1 on DEB consecutive tick cycles.
  - Al clears after fault has been 0 on DEB consecutive tick cycles.
  - A single tick with the opposite value restarts the debounce count.
- Fill FSM, two states:
  - HOLD -> FILL when ~M & ~Al.
  - FILL -> HOLD when H or Al.
  - Ve = 1 only in FILL.
  - An empty tank (H=M=L=0) is valid and causes filling.
- Irrigation FSM: IDLE, RUN, PAUSE.
  - IDLE: search from the pointer upward, wrapping modulo ZONES, for the first zone with Us[i]=0. The run may start only when L=1 and Al=0.
  - IDLE -> RUN: if a zone is found, on the next clk edge zone_en=one-hot(i), the run timer is cleared and busy=1.
  - Mode is latched at RUN entry: drip (Vs=1, Bs=0) if Ua|T, else spray (Bs=1, Vs=0). Mode does not change during the run even if Ua or T change.
  - RUN -> PAUSE when any of the following holds:
    - Us[i]=1 (zone wet): normal end.
    - run timer reaches MAX_RUN on a tick: sets timeout_flags[i].
    - L=0 or Al=1: abort.
  - On entering PAUSE: zone_en, Bs and Vs go 0 on the same edge; pointer = (i+1) mod ZONES; pause timer cleared.
  - PAUSE -> IDLE after GAP ticks. busy=0 in IDLE.
  - Priority when end conditions coincide in one cycle: abort > timeout > wet. A timeout on the same cycle as the zone going wet still sets the flag.
- Fairness: after zone i runs, zone i is not considered again until every other dry zone has had a turn.
- Timers saturate and never wrap; TW must hold MAX_RUN, GAP and DEB.
- clr: clears timeout_flags on the next edge. If a flag set and clr occur on the same cycle, the set wins.
- Reset asserted mid-run: all valves and the pump go off immediately (asynchronously). After reset, scheduling restarts at zone 0.
- ZONES=1: the pointer stays 0; behaviour is otherwise identical.

Test Plan:
- Reset with tick=1, H=M=L=0, Us=all 1 -> all outputs 0 while rst_n=0; one cycle after release, Ve=1 (fill); Ve stays 1 through M=1 and drops the cycle after H=1; Al stays 0.
- Level fault: H=1, M=0, L=1 for 2 ticks, then M=1 -> Al stays 0. Hold H=1, M=0 for 3 ticks -> Al=1 after the 3rd tick and Ve forced 0. Restore a consistent level for 3 ticks -> Al=0.
- Tank full, ZONES=4, Us=4'b1010 (zones 0 and 2 dry), Ua=T=0 -> zone_en=0001 with Bs=1. Set Us[0]=1 -> PAUSE for 10 ticks, then zone_en=0100. After zone 2 also goes wet -> idle, pointer=3.
- Zone 1 dry with T=1 -> Vs=1, Bs=0. Toggle T mid-run -> mode unchanged. Keep Us[1]=0 for 600 ticks -> run ends, timeout_flags=0010. Pulse clr -> flags=0000.
- During a run of zone 3, drop L to 0 -> zone_en, Bs and Vs all 0 on the next edge; PAUSE; no new run while L=0; timeout_flags unchanged.
- Asynchronous reset asserted mid-run, between clock edges -> zone_en, Bs, Vs and busy go 0 without waiting for a clock edge; after release the first dry zone served is the lowest-numbered one.
